mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported word memory.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise data always wins.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  // data side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_adr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last_grant;  // 0 = fetch, 1 = data
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_adr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                w_pick_dm;
  logic                w_if_done;
  logic                w_dm_done;

`ifdef ARB_RR_EN
  // On a tie, the data side wins only if fetch was served last.
  assign w_pick_dm = dm_req & (~if_req | ~r_last_grant);
`else
  // last_grant is still tracked but has no influence on a fixed-priority decision.
  assign w_pick_dm = dm_req | (r_last_grant & 1'b0);
`endif

  assign w_if_done = (r_state == IF_BUSY) & mem_ack;
  assign w_dm_done = (r_state == DM_BUSY) & mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_adr    <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_dm) begin
            r_state      <= DM_BUSY;
            r_last_grant <= 1'b1;
            r_mem_req    <= 1'b1;
            r_mem_we     <= dm_we;
            r_mem_adr    <= dm_adr;
            r_mem_wdata  <= dm_wdata;
          end else if (if_req) begin
            r_state      <= IF_BUSY;
            r_last_grant <= 1'b0;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_adr    <= if_adr;
            r_mem_wdata  <= '0;
          end
        end
        IF_BUSY, DM_BUSY: begin
          // The command stays frozen until the memory acknowledges, even if req drops.
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_adr   = r_mem_adr;
  assign mem_wdata = r_mem_wdata;

  assign if_done   = w_if_done;
  assign dm_done   = w_dm_done;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign if_stall  = if_req & ~w_if_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a transaction-level reference model.
// Honours ARB_RR_EN the same way as the design build.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_adr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_adr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who currently owns the memory (0 none, 1 fetch, 2 data) and the command it issued.
  int            m_owner = 0;
  logic          m_last = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            m_if_fired, m_dm_fired;
  logic [AW-1:0] dut_grants[$];
  logic          prev_req = 1'b0;
  bit            if_pend = 0, dm_pend = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tie_winner();
`ifdef ARB_RR_EN
    return m_last ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  task automatic compare_all();
    bit e_if, e_dm;
    e_if = (m_owner == 1) && mem_ack;
    e_dm = (m_owner == 2) && mem_ack;
    chk("mem_req", mem_req, m_owner != 0);
    chk("if_done", if_done, e_if);
    chk("dm_done", dm_done, e_dm);
    chk("if_stall", if_stall, if_req && !e_if);
    if (m_owner != 0) begin
      chk("mem_adr", mem_adr, m_adr);
      chk("mem_we", mem_we, m_we);
      if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_if) chk("if_rdata", if_rdata, mem_rdata);
    if (e_dm) chk("dm_rdata", dm_rdata, mem_rdata);
  endtask

  task automatic model_update();
    int w;
    m_if_fired = 0;
    m_dm_fired = 0;
    if (reset) begin
      m_owner = 0;
      m_last  = 1'b0;
    end else if (m_owner != 0) begin
      if (mem_ack) begin
        m_if_fired = (m_owner == 1);
        m_dm_fired = (m_owner == 2);
        m_owner    = 0;
      end
    end else if (dm_req || if_req) begin
      w = (dm_req && if_req) ? tie_winner() : (dm_req ? 2 : 1);
      m_owner = w;
      m_last  = (w == 2);
      if (w == 2) begin
        m_we = dm_we; m_adr = dm_adr; m_wdata = dm_wdata;
      end else begin
        m_we = 1'b0; m_adr = if_adr;
      end
    end
  endtask

  task automatic half_a();
    @(negedge clk);
    compare_all();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    half_a();
    half_b();
  endtask

  logic [AW-1:0] exp_seq[4];

  initial begin
    // Reset state, with a stray ack present
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_adr", mem_adr, 12'h000);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_done", if_done, 1'b0);
    chk("rst_dm_done", dm_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    half_b();

    // Spurious ack in IDLE
    repeat (3) begin
      half_a();
      chk("spur_mem_req", mem_req, 1'b0);
      chk("spur_done", {if_done, dm_done}, 2'b00);
      half_b();
    end
    mem_ack = 1'b0;

    // Fetch with ack two cycles after mem_req
    if_req = 1'b1; if_adr = 12'h004;
    step();
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    half_a();
    chk("fetch_done", if_done, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    chk("fetch_adr", mem_adr, 12'h004);
    chk("fetch_we", mem_we, 1'b0);
    chk("fetch_stall_end", if_stall, 1'b0);
    half_b();
    if_req = 1'b0; mem_ack = 1'b0;
    step();

    // Store with immediate ack
    dm_req = 1'b1; dm_we = 1'b1; dm_adr = 12'h010; dm_wdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b1;
    half_a();
    chk("store_we", mem_we, 1'b1);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store_done", dm_done, 1'b1);
    chk("store_if_done", if_done, 1'b0);
    half_b();
    dm_req = 1'b0; mem_ack = 1'b0;
    step();

    // Fetch arriving while data owns the memory
    dm_req = 1'b1; dm_we = 1'b0; dm_adr = 12'h020;
    step();
    if_req = 1'b1; if_adr = 12'h008;
    half_a();
    chk("wait_stall0", if_stall, 1'b1);
    half_b();
    mem_ack = 1'b1;
    half_a();
    chk("wait_dm_done", dm_done, 1'b1);
    chk("wait_stall1", if_stall, 1'b1);
    half_b();
    dm_req = 1'b0; mem_ack = 1'b0;
    half_a();
    chk("wait_bubble_req", mem_req, 1'b0);
    chk("wait_stall2", if_stall, 1'b1);
    half_b();
    mem_ack = 1'b1;
    half_a();
    chk("wait_fetch_adr", mem_adr, 12'h008);
    chk("wait_fetch_done", if_done, 1'b1);
    half_b();
    if_req = 1'b0; mem_ack = 1'b0;
    step();

    // Reset in the middle of a fetch access
    if_req = 1'b1; if_adr = 12'h00C;
    step();
    step();
    step();
    #2;
    reset = 1'b1;
    m_owner = 0; m_last = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_if_done", if_done, 1'b0);
    chk("arst_mem_adr", mem_adr, 12'h000);
    if_req = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Both requesting from reset, ack always high
    if_req = 1'b1; if_adr = 12'h100;
    dm_req = 1'b1; dm_we = 1'b1; dm_adr = 12'h200; dm_wdata = 32'h12345678;
    mem_ack = 1'b1;
    prev_req = 1'b0;
    repeat (8) begin
      half_a();
      if (mem_req && !prev_req) dut_grants.push_back(mem_adr);
      prev_req = mem_req;
      half_b();
    end
`ifdef ARB_RR_EN
    exp_seq = '{12'h200, 12'h100, 12'h200, 12'h100};
`else
    exp_seq = '{12'h200, 12'h200, 12'h200, 12'h200};
`endif
    chk("both_ngrants", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("both_grant%0d", i), (i < dut_grants.size()) ? dut_grants[i] : 12'hFFF, exp_seq[i]);
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    step();
    step();

    // Randomized traffic against the model
    repeat (3000) begin
      step();
      if (m_if_fired) if_pend = 0;
      if (m_dm_fired) dm_pend = 0;
      if (if_pend && $urandom_range(0, 49) == 0) if_pend = 0;
      if (dm_pend && $urandom_range(0, 49) == 0) dm_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        if_adr  = AW'($urandom);
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend  = 1;
        dm_we    = $urandom_range(0, 1) == 1;
        dm_adr   = AW'($urandom);
        dm_wdata = $urandom;
      end
      if_req    = if_pend;
      dm_req    = dm_pend;
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
